// File: rtl/spi_slave_if.sv
// User-side port bundle of the SPI slave: TX holding-buffer handshake, RX word
// delivery and status pulses.
// Handshake: tx_data is written into the holding buffer on a clk edge where
// tx_valid && tx_ready; tx_valid may be held high and tx_data must be stable while
// tx_valid is high. RX has no ready: rx_data must be captured in the rx_valid cycle.
interface spi_slave_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  tx_underrun;
    logic                  frame_err;
    logic                  busy;

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, rx_data, rx_valid, tx_underrun, frame_err, busy
    );

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, rx_data, rx_valid, tx_underrun, frame_err, busy
    );
endinterface

// File: rtl/spi_slave.sv
// SPI peripheral: oversamples sclk/ss_n/mosi in the clk domain, shifts MSB-first
// words both ways and refills its shifter from a one-word TX holding buffer.
module spi_slave #(
    parameter logic [1:0] SPI_MODE    = 2'd0,
    parameter int         DATA_WIDTH  = 8,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sclk_i,
    input  logic        ss_n_i,
    input  logic        mosi_i,
    output logic        miso_o,
    output logic        miso_oe_o,
    output logic        dbg_state_o,
    spi_slave_if.slave  usr
);
    localparam logic CPOL  = SPI_MODE[1];
    localparam logic CPHA  = SPI_MODE[0];
    localparam int   CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0]  ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0]  mosi_sync_q, mosi_sync_d;
    logic                    sclk_prev_q, sclk_prev_d;
    logic                    primed_q, primed_d;
    logic                    armed_q, armed_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   rx_sh_q, rx_sh_d;
    logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic                    rx_valid_q, rx_valid_d;
    logic [DATA_WIDTH-1:0]   tx_sh_q, tx_sh_d;
    logic [DATA_WIDTH-1:0]   buf_q, buf_d;
    logic                    buf_full_q, buf_full_d;
    logic                    underrun_q, underrun_d;
    logic                    frame_err_q, frame_err_d;

    logic sclk_s, ss_s, mosi_s;
    logic sclk_rise, sclk_fall, sample_edge, shift_edge;
    logic load;

    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s        = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise   = sclk_s & ~sclk_prev_q;
    assign sclk_fall   = ~sclk_s & sclk_prev_q;
    assign sample_edge = (CPOL == CPHA) ? sclk_rise : sclk_fall;
    assign shift_edge  = (CPOL == CPHA) ? sclk_fall : sclk_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sclk_sync_q <= {SYNC_STAGES{CPOL}};
            ss_sync_q   <= {SYNC_STAGES{1'b1}};
            mosi_sync_q <= '0;
            sclk_prev_q <= CPOL;
            primed_q    <= 1'b0;
            armed_q     <= 1'b0;
            bit_cnt_q   <= '0;
            rx_sh_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            tx_sh_q     <= '0;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
            underrun_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            ss_sync_q   <= ss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            primed_q    <= primed_d;
            armed_q     <= armed_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sh_q     <= rx_sh_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_sh_q     <= tx_sh_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
            underrun_q  <= underrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss_n_i};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
        sclk_prev_d = sclk_s;
        primed_d    = 1'b1;
        // Only a genuinely observed high ss_n arms frame entry, so a reset taken
        // with ss_n held low does not fake a fresh select.
        armed_d     = armed_q | (primed_q & ss_sync_q[0]);
        bit_cnt_d   = bit_cnt_q;
        rx_sh_d     = rx_sh_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_sh_d     = tx_sh_q;
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        underrun_d  = 1'b0;
        frame_err_d = 1'b0;
        load        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (armed_q && !ss_s) begin
                    state_d   = ST_ACTIVE;
                    bit_cnt_d = '0;
                    load      = ~CPHA;
                end
            end
            ST_ACTIVE: begin
                if (ss_s) begin
                    state_d     = ST_IDLE;
                    bit_cnt_d   = '0;
                    rx_sh_d     = '0;
                    frame_err_d = (bit_cnt_q != '0);
                end else if (sample_edge) begin
                    rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], mosi_s};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d  = '0;
                        rx_data_d  = {rx_sh_q[DATA_WIDTH-2:0], mosi_s};
                        rx_valid_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (shift_edge) begin
                    // A shift edge at bit 0 opens a new word in both phases.
                    if (bit_cnt_q == '0) begin
                        load = 1'b1;
                    end else begin
                        tx_sh_d = {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            if (buf_full_q) begin
                tx_sh_d    = buf_q;
                buf_full_d = 1'b0;
            end else begin
                tx_sh_d    = '0;
                underrun_d = 1'b1;
            end
        end

        // Write is judged on the pre-load buffer state: no bypass into tx_sh.
        if (usr.tx_valid && !buf_full_q) begin
            buf_d      = usr.tx_data;
            buf_full_d = 1'b1;
        end
    end

    assign miso_o          = (state_q == ST_ACTIVE) & tx_sh_q[DATA_WIDTH-1];
    assign miso_oe_o       = (state_q == ST_ACTIVE);
    assign dbg_state_o     = (state_q == ST_ACTIVE);
    assign usr.tx_ready    = ~buf_full_q;
    assign usr.rx_data     = rx_data_q;
    assign usr.rx_valid    = rx_valid_q;
    assign usr.tx_underrun = underrun_q;
    assign usr.frame_err   = frame_err_q;
    assign usr.busy        = ~ss_s;
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: one instance per SPI mode driven by a behavioural SPI master,
// with the exchanged words checked against a word-level model of the TX buffer.
module tb_spi_slave;
    localparam int H = 8;  // sclk half-period in clk cycles

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [3:0] sclk_p, ss_n_p, mosi_p, tx_valid_p;
    logic [7:0] tx_data_a [4];
    logic [7:0] rx_data_a [4];
    logic miso_a [4], miso_oe_a [4], dbg_a [4], tx_ready_a [4];
    logic rx_valid_a [4], ur_a [4], fe_a [4], busy_a [4];

    int cur, cyc, n_checks, n_fail, n_ur, n_fe, first_ur, ss_cyc, d_ur;
    logic [7:0] m_tx[$], m_rx[$], got_rx[$], feed_w[$];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_if #(.DATA_WIDTH(8)) bus ();
        assign bus.tx_data    = tx_data_a[g];
        assign bus.tx_valid   = tx_valid_p[g];
        assign tx_ready_a[g]  = bus.tx_ready;
        assign rx_data_a[g]   = bus.rx_data;
        assign rx_valid_a[g]  = bus.rx_valid;
        assign ur_a[g]        = bus.tx_underrun;
        assign fe_a[g]        = bus.frame_err;
        assign busy_a[g]      = bus.busy;
        spi_slave #(.SPI_MODE(2'(g)), .DATA_WIDTH(8), .SYNC_STAGES(2)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .sclk_i     (sclk_p[g]),
            .ss_n_i     (ss_n_p[g]),
            .mosi_i     (mosi_p[g]),
            .miso_o     (miso_a[g]),
            .miso_oe_o  (miso_oe_a[g]),
            .dbg_state_o(dbg_a[g]),
            .usr        (bus)
        );
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor for the instance under test
    always @(negedge clk) begin
        if (rx_valid_a[cur]) got_rx.push_back(rx_data_a[cur]);
        if (ur_a[cur]) begin
            n_ur++;
            if (first_ur < 0) first_ur = cyc;
        end
        if (fe_a[cur]) n_fe++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (mode %0d): got %0h expected %0h", tag, cur, got, exp);
        end
    endtask

    task automatic clear_obs();
        m_rx.delete();
        got_rx.delete();
        n_ur = 0;
        n_fe = 0;
        first_ur = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_miso"},     miso_a[cur],     1'b0);
        check_eq({tag, "_miso_oe"},  miso_oe_a[cur],  1'b0);
        check_eq({tag, "_rx_data"},  rx_data_a[cur],  8'h00);
        check_eq({tag, "_rx_valid"}, rx_valid_a[cur], 1'b0);
        check_eq({tag, "_tx_ready"}, tx_ready_a[cur], 1'b1);
        check_eq({tag, "_underrun"}, ur_a[cur],       1'b0);
        check_eq({tag, "_frame_err"},fe_a[cur],       1'b0);
        check_eq({tag, "_busy"},     busy_a[cur],     1'b0);
    endtask

    // Called on a negedge; returns on a negedge after the word was taken.
    task automatic feed_word(input logic [7:0] w);
        int guard;
        guard = 0;
        tx_data_a[cur] = w;
        tx_valid_p[cur] = 1'b1;
        while (!tx_ready_a[cur] && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check_eq("feed_ready", tx_ready_a[cur], 1'b1);
        @(negedge clk);
        tx_valid_p[cur] = 1'b0;
    endtask

    // Behavioural master: nbits bits of m_tx, MSB first; completed words go to m_rx.
    task automatic spi_frame(input int nbits, input bit raise_ss);
        logic cpha;
        logic [7:0] in_w;
        int wi, bi, nb;
        cpha = cur[0];
        in_w = 8'h00;
        @(negedge clk);
        ss_cyc = cyc;
        ss_n_p[cur] = 1'b0;
        if (!cpha) mosi_p[cur] = m_tx[0][7];
        repeat (8) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            wi = b / 8;
            bi = 7 - (b % 8);
            if (cpha) begin
                sclk_p[cur] = ~sclk_p[cur];
                mosi_p[cur] = m_tx[wi][bi];
                repeat (H) @(negedge clk);
                in_w = {in_w[6:0], miso_a[cur]};
                sclk_p[cur] = ~sclk_p[cur];
                repeat (H) @(negedge clk);
            end else begin
                in_w = {in_w[6:0], miso_a[cur]};
                sclk_p[cur] = ~sclk_p[cur];
                repeat (H) @(negedge clk);
                sclk_p[cur] = ~sclk_p[cur];
                nb = b + 1;
                mosi_p[cur] = (nb < nbits) ? m_tx[nb / 8][7 - (nb % 8)] : 1'b0;
                repeat (H) @(negedge clk);
            end
            if (bi == 0) m_rx.push_back(in_w);
        end
        if (raise_ss) begin
            repeat (4) @(negedge clk);
            ss_n_p[cur] = 1'b1;
            mosi_p[cur] = 1'b0;
            repeat (8) @(negedge clk);
        end
    endtask

    // Full frame of nw words with nf buffer words offered in order. Each load point
    // takes the next offered word, or sends zeros once the offered words run out.
    task automatic do_xfer(input int nw, input int nf);
        int loads;
        clear_obs();
        fork
            begin
                for (int i = 0; i < nf; i++) feed_word(feed_w[i]);
            end
            spi_frame(nw * 8, 1'b1);
        join
        loads = nw + (cur[0] ? 0 : 1);
        check_eq("rx_count", got_rx.size(), nw);
        check_eq("master_count", m_rx.size(), nw);
        for (int i = 0; i < nw; i++) begin
            if (i < got_rx.size()) check_eq("rx_word", got_rx[i], m_tx[i]);
            if (i < m_rx.size()) check_eq("miso_word", m_rx[i], (i < nf) ? feed_w[i] : 8'h00);
        end
        check_eq("underruns", n_ur, loads - nf);
        check_eq("frame_err", n_fe, 0);
        check_eq("rx_data_hold", rx_data_a[cur], m_tx[nw-1]);
        check_eq("idle_after", miso_oe_a[cur], 1'b0);
    endtask

    initial begin
        int nw, loads, nf;
        rst_n = 1'b0;
        sclk_p = 4'b1100;
        ss_n_p = 4'hF;
        mosi_p = 4'h0;
        tx_valid_p = 4'h0;
        for (int i = 0; i < 4; i++) tx_data_a[i] = 8'h00;
        cur = 0;
        first_ur = -1;
        repeat (3) @(negedge clk);
        for (int m = 0; m < 4; m++) begin
            cur = m;
            check_reset_outputs("reset");
        end
        cur = 0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Mode 0 single word
        m_tx = {8'h3C};
        feed_w = {8'hA5, 8'h00};
        do_xfer(1, 2);

        // Back-to-back words in one select
        m_tx = {8'h01, 8'h02, 8'h03};
        feed_w = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
        do_xfer(3, 4);

        // Empty buffer: measure where the first load lands, then write exactly there
        m_tx = {8'h6C};
        feed_w.delete();
        do_xfer(1, 0);
        d_ur = first_ur - ss_cyc;
        check_eq("load_latency_seen", (d_ur >= 1 && d_ur < 20), 1'b1);
        clear_obs();
        m_tx = {8'h93, 8'h4E};
        fork
            spi_frame(16, 1'b1);
            begin
                @(negedge clk);
                repeat (d_ur - 1) @(negedge clk);
                tx_data_a[0] = 8'h5A;
                tx_valid_p[0] = 1'b1;
                @(negedge clk);
                tx_valid_p[0] = 1'b0;
                feed_word(8'h77);
            end
        join
        check_eq("nobypass_w0", (m_rx.size() > 0) ? m_rx[0] : 8'hEE, 8'h00);
        check_eq("nobypass_w1", (m_rx.size() > 1) ? m_rx[1] : 8'hEE, 8'h5A);
        check_eq("nobypass_underruns", n_ur, 1);
        check_eq("nobypass_rx", got_rx.size(), 2);

        // ss_n raised after 5 bits
        clear_obs();
        m_tx = {8'hB6};
        fork
            feed_word(8'hC3);
            spi_frame(5, 1'b1);
        join
        check_eq("abort_frame_err", n_fe, 1);
        check_eq("abort_no_rx", got_rx.size(), 0);
        check_eq("abort_underruns", n_ur, 0);
        m_tx = {8'hE7};
        feed_w = {8'h3A, 8'h55};
        do_xfer(1, 2);

        // Modes 1..3 with the 81/7E pattern
        for (int m = 1; m < 4; m++) begin
            cur = m;
            m_tx = {8'h81, 8'h7E};
            feed_w = {8'h7E, 8'h81, 8'hFF};
            do_xfer(2, m[0] ? 2 : 3);
        end

        // Randomized frames in every mode
        for (int m = 0; m < 4; m++) begin
            for (int r = 0; r < 3; r++) begin
                cur = m;
                nw = $urandom_range(1, 3);
                loads = nw + (m[0] ? 0 : 1);
                nf = $urandom_range(loads - 1, loads);
                m_tx.delete();
                feed_w.delete();
                for (int i = 0; i < nw; i++) m_tx.push_back(8'($urandom_range(0, 255)));
                for (int i = 0; i < nf; i++) feed_w.push_back(8'($urandom_range(0, 255)));
                do_xfer(nw, nf);
            end
        end

        // Reset in the middle of a word
        cur = 0;
        clear_obs();
        m_tx = {8'h9D};
        fork
            feed_word(8'h11);
            spi_frame(4, 1'b0);
        join
        check_eq("pre_reset_busy", busy_a[0], 1'b1);
        check_eq("pre_reset_oe", miso_oe_a[0], 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        ss_n_p[0] = 1'b1;
        mosi_p[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        clear_obs();
        for (int i = 0; i < 16; i++) begin
            sclk_p[0] = ~sclk_p[0];
            mosi_p[0] = 1'($urandom_range(0, 1));
            repeat (H) @(negedge clk);
        end
        mosi_p[0] = 1'b0;
        check_eq("desel_no_rx", got_rx.size(), 0);
        check_eq("desel_busy", busy_a[0], 1'b0);
        check_eq("desel_rx_data", rx_data_a[0], 8'h00);
        m_tx = {8'h5E};
        feed_w = {8'hC9, 8'h00};
        do_xfer(1, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
